// File: rtl/mem_loader.sv
// mem_loader: takes a length-prefixed little-endian byte stream, writes it word by word into RAM,
// and holds the core in reset until the load is done. Define LOADER_CSUM_EN for an XOR trailer check.
module mem_loader #(
  parameter logic [13:0] BASE_ADDR = 14'h0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [13:0] ld_addr,
  output logic [31:0] ld_data,
  output logic [1:0]  ld_size,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned CntW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    StLen,
    StData,
    StWrite,
`ifdef LOADER_CSUM_EN
    StCsum,
`endif
    StDone,
    StErr
  } state_e;

`ifdef LOADER_CSUM_EN
  localparam state_e StTail = StCsum;
`else
  localparam state_e StTail = StDone;
`endif

  state_e          state_q, state_d;
  logic            run_q;
  logic [1:0]      cnt_q, cnt_d;
  logic [23:0]     buf_q, buf_d;
  logic [CntW-1:0] n_q, n_d;
  logic [CntW-1:0] k_q, k_d;
  logic [13:0]     ld_addr_q, ld_addr_d;
  logic [31:0]     ld_data_q, ld_data_d;
  logic            xfer;
  logic            last_byte;
  logic            st_csum;
  logic [31:0]     full;

`ifdef LOADER_CSUM_EN
  logic [31:0] csum_q, csum_d;
  assign st_csum = (state_q == StCsum);
`else
  assign st_csum = 1'b0;
`endif

  assign xfer      = in_valid && in_ready;
  assign last_byte = xfer && (cnt_q == 2'd3);
  assign full      = {in_data, buf_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    n_d       = n_q;
    k_d       = k_q;
    ld_addr_d = ld_addr_q;
    ld_data_d = ld_data_q;
`ifdef LOADER_CSUM_EN
    csum_d    = csum_q;
`endif

    // One byte gatherer serves header, payload and trailer; the 4th byte is used straight from in_data.
    if (xfer) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    buf_d[7:0]   = in_data;
        2'd1:    buf_d[15:8]  = in_data;
        2'd2:    buf_d[23:16] = in_data;
        default: ;
      endcase
    end

    unique case (state_q)
      StLen: begin
        if (last_byte) begin
          if (full == 32'd0) begin
            state_d = StTail;
          end else if (full > 32'(MAX_WORDS)) begin
            state_d = StErr;
          end else begin
            n_d     = CntW'(full);
            state_d = StData;
          end
        end
      end
      StData: begin
        if (last_byte) begin
          ld_data_d = full;
          ld_addr_d = BASE_ADDR + 14'({k_q, 2'b00});
          state_d   = StWrite;
        end
      end
      StWrite: begin
`ifdef LOADER_CSUM_EN
        csum_d = csum_q ^ ld_data_q;
`endif
        if (k_q + CntW'(1) == n_q) begin
          state_d = StTail;
        end else begin
          k_d     = k_q + CntW'(1);
          state_d = StData;
        end
      end
`ifdef LOADER_CSUM_EN
      StCsum: begin
        if (last_byte) begin
          state_d = (full == csum_q) ? StDone : StErr;
        end
      end
`endif
      StDone, StErr: ;
      default: state_d = StErr;
    endcase
  end

  // run_q keeps in_ready low for the first cycle out of reset.
  assign in_ready  = run_q && (state_q == StLen || state_q == StData || st_csum);
  assign ld_size   = (state_q == StWrite) ? 2'b11 : 2'b00;
  assign ld_addr   = ld_addr_q;
  assign ld_data   = ld_data_q;
  assign core_hold = (state_q != StDone);
  assign done      = (state_q == StDone);
  assign err       = (state_q == StErr);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StLen;
      run_q     <= 1'b0;
      cnt_q     <= 2'd0;
      buf_q     <= 24'd0;
      n_q       <= '0;
      k_q       <= '0;
      ld_addr_q <= BASE_ADDR;
      ld_data_q <= 32'd0;
`ifdef LOADER_CSUM_EN
      csum_q    <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      n_q       <= n_d;
      k_q       <= k_d;
      ld_addr_q <= ld_addr_d;
      ld_data_q <= ld_data_d;
`ifdef LOADER_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 14'h0000, byte address in RAM where the first loaded word is written; word-aligned.
REQ-002 Parameter MAX_WORDS, default 4096, largest accepted word count, matching the 16 KB RAM.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 resetn  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  a byte is offered on in_data.
REQ-006 in_data  input  8  byte stream: 4-byte length header, then payload words; all little-endian.
REQ-007 in_ready  output  1  loader accepts in_data this cycle; a byte transfers when in_valid && in_ready.
REQ-008 ld_addr  output  14  RAM write byte address.
REQ-009 ld_data  output  32  RAM write data.
REQ-010 ld_size  output  2  RAM write size; 2'b11 means a full-word write, 2'b00 means no write.
REQ-011 core_hold  output  1  holds the CPU in reset while high.
REQ-012 done  output  1  the image is completely and correctly loaded.
REQ-013 err  output  1  the load is aborted; sticky until reset.

Function
REQ-014 States: LEN, DATA, WRITE, CSUM, DONE, ERR.
REQ-015 LEN: accept 4 bytes into a 32-bit word count N, first byte in bits [7:0].
- N == 0: go to CSUM if the checksum is compiled in, otherwise to DONE.
- N > MAX_WORDS: go to ERR.
- Otherwise: go to DATA.
REQ-016 DATA: accept 4 bytes and assemble a word, first byte in bits [7:0]; the cycle after the 4th byte is accepted, enter WRITE.
REQ-017 WRITE lasts exactly one cycle, with:
- ld_size = 2'b11;
- ld_addr = BASE_ADDR + 4*k (k = 0-based word index);
- ld_data = assembled word.
REQ-018 After WRITE: if k+1 == N, go to CSUM (feature in) or DONE; otherwise increment k and return to DATA.
REQ-019 Outside WRITE, ld_size = 2'b00; ld_addr and ld_data hold their last values.
REQ-020 in_ready = 1 in LEN, DATA and CSUM; in_ready = 0 in WRITE, DONE and ERR.
REQ-021 Bytes offered while in_ready = 0 are not consumed.
REQ-022 in_valid low for any number of cycles stalls the current state without losing partial bytes.
REQ-023 Address arithmetic is 14-bit modulo; MAX_WORDS guarantees that no word wraps past BASE_ADDR + 16 KB when BASE_ADDR = 0.
REQ-024 core_hold = 1 in every state except DONE; in DONE, core_hold = 0 and done = 1.
REQ-025 ERR: err = 1, core_hold = 1, done = 0, no writes.
REQ-026 DONE and ERR are terminal; only reset leaves them.
REQ-027 Throughput: one word per 5 cycles when in_valid is held high.

Reset
REQ-028 When resetn is sampled low, the loader enters the following state on that edge:
- state LEN, k = 0, partial-byte count 0, checksum accumulator 0;
- ld_size = 2'b00, ld_addr = BASE_ADDR, ld_data = 0;
- core_hold = 1, done = 0, err = 0, in_ready = 0.
REQ-029 in_ready rises the first cycle after resetn is sampled high.
REQ-030 Reset during WRITE suppresses that write: ld_size is 2'b00 on the following cycle.
REQ-031 Reset in DONE re-asserts core_hold and restarts the load.

Configuration
REQ-032 Macro LOADER_CSUM_EN.
REQ-033 When LOADER_CSUM_EN is defined:
- the accumulator XORs every written word;
- CSUM accepts a 4-byte little-endian trailer;
- match goes to DONE, mismatch goes to ERR;
- the mismatch decision is made the cycle after the 4th trailer byte.
REQ-034 When LOADER_CSUM_EN is undefined:
- there is no CSUM state, no trailer and no accumulator logic;
- the last WRITE goes directly to DONE;
- err is set only by an oversized N.

Verification
REQ-035 Send N=2 (02 00 00 00), then 78 56 34 12 and EF BE AD DE, with in_valid held high -> two 1-cycle writes: 0x0000/0x12345678, then 0x0004/0xDEADBEEF; done = 1 and core_hold = 0 after the second write (macro off).
REQ-036 Send N=0 -> no write; DONE the cycle after the 4th header byte (macro off); with the macro on, a trailer 00 00 00 00 gives DONE.
REQ-037 Send N=4097 (01 10 00 00) -> ERR: err = 1, core_hold = 1, in_ready = 0, and ld_size never equals 2'b11.
REQ-038 Send N=1, word 0xA5A5A5A5, with in_valid toggling every other cycle -> exactly one write of 0xA5A5A5A5 at BASE_ADDR; no byte dropped or duplicated.
REQ-039 Macro on, N=2, words 0x11111111 and 0x22222222:
- trailer 0x33333333 -> DONE;
- trailer 0x33333334 -> ERR with core_hold = 1.
REQ-040 Assert resetn low for one cycle after 2 bytes of the first word -> state LEN, core_hold = 1, no write issued; then a fresh N=1 load writes at BASE_ADDR.
